fb_pixel_sink: RTL and testbench
================================

// Module: fb_pixel_sink
// PURPOSE
//  Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the cube/screen drawers.
//  Stores every plotted pixel in an on-chip frame buffer. On request, scans the frame out in raster order
//  over a valid/ready stream. Used as the display-side sink and as a readback path for verifying drawer output.
// PARAMETERS
//  WIDTH   160  frame width in pixels; x range 0..WIDTH-1
//  HEIGHT  120  frame height in pixels; y range 0..HEIGHT-1
//  CW      9    colour width (3 bits each of R, G, B)
// PORTS
//  clk         in   1    single clock; all logic is on its rising edge
//  resetn      in   1    reset, synchronous, active-low
//  x           in   8    plot column
//  y           in   7    plot row
//  colour      in   CW   plot colour
//  plot        in   1    write strobe; one pixel is accepted per cycle when high (no backpressure)
//  scan_start  in   1    one-cycle pulse; starts a full-frame scan-out
//  out_valid   out  1    out_x/out_y/out_colour hold a scanned pixel
//  out_ready   in   1    consumer accepts the pixel when out_valid && out_ready
//  out_x       out  8    column of the scanned pixel
//  out_y       out  7    row of the scanned pixel
//  out_colour  out  CW   colour of the scanned pixel
//  scan_busy   out  1    high from the cycle after an accepted scan_start until the last pixel is accepted
//  frame_done  out  1    one-cycle pulse in the cycle after the last pixel (x=WIDTH-1, y=HEIGHT-1) is accepted
//  oob_count   out  8    saturating count of plots dropped as out of range
// BEHAVIOUR
//  Reset values (resetn low at the clock edge):
//   - out_valid=0, scan_busy=0, frame_done=0, oob_count=0.
//   - out_x, out_y and out_colour are 0.
//   - Scan counters are 0 and the FSM is IDLE.
//   - Frame buffer contents are NOT cleared; drawers clear the screen by plotting.
//  Write side:
//   - Plot with x<WIDTH and y<HEIGHT writes mem[y*WIDTH+x] <= colour at the edge.
//   - Address arithmetic is 15 bits wide, with no overflow for the defaults (max address 19199).
//   - Plot with x>=WIDTH or y>=HEIGHT: no write; oob_count increments and saturates at 255.
//   - Writes are accepted in every FSM state, including during a scan.
//  Read-during-write to the same address in the same cycle returns the OLD data.
//  FSM:
//   - IDLE:
//     - scan_start -> SCAN; rd_x=0, rd_y=0.
//   - SCAN:
//     - advance = !out_valid || out_ready.
//     - On advance (RAM output register and output stage are the same register, 1-cycle read latency):
//       out_colour <= mem[rd_y*WIDTH+rd_x], out_x <= rd_x, out_y <= rd_y, out_valid <= 1.
//     - rd_x increments; at WIDTH-1 it wraps to 0 and rd_y increments.
//     - Once the last pixel has been issued -> DRAIN.
//     - While out_valid && !out_ready, all output fields stay stable.
//   - DRAIN:
//     - When the last pixel is accepted: out_valid <= 0, frame_done <= 1 for one cycle, -> IDLE.
//  scan_busy = (state != IDLE).
//  scan_start while in SCAN or DRAIN is ignored; it does not restart the scan.
//  First out_valid asserts 1 cycle after scan_start.
//  With out_ready held high, one pixel is delivered per cycle: WIDTH*HEIGHT consecutive beats.
//  frame_done comes 1 cycle after the final beat.
//  Reset asserted mid-scan: the scan is aborted immediately, the outputs take their reset values,
//  and no frame_done is produced.
// TESTING
//  1. Reset, plot (5,3,9'h1C7) then scan with out_ready=1 -> beat 485 has out_x=5, out_y=3,
//     out_colour=9'h1C7; 19200 beats total; frame_done 1 cycle after the last beat.
//  2. Plot (160,0) and (0,120), each once -> no memory change; oob_count=2.
//     Send 300 such plots -> oob_count=255.
//  3. Scan with out_ready toggling 1,0,0,1,... -> out_x/out_y/out_colour stable while stalled;
//     no pixel is skipped or duplicated; addresses are strictly in raster order.
//  4. Same-cycle plot and scan read of address (10,0) with old value A and new value B
//     -> scan emits A; a second scan emits B.
//  5. scan_start pulsed again at beat 100 -> ignored; exactly 19200 beats; one frame_done.
//  6. resetn low at beat 50 -> next cycle out_valid=0, scan_busy=0, no frame_done.
//     A new scan returns the pre-reset frame contents.

Source files
------------

// File: rtl/fb_pixel_sink.sv
// Pixel-plot sink: stores plotted pixels in an on-chip frame buffer and scans the
// whole frame out in raster order over a valid/ready stream on request.
module fb_pixel_sink #(
   parameter int unsigned WIDTH  = 160,
   parameter int unsigned HEIGHT = 120,
   parameter int unsigned CW     = 9
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [7:0]    x,
   input  logic [6:0]    y,
   input  logic [CW-1:0] colour,
   input  logic          plot,
   input  logic          scan_start,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_x,
   output logic [6:0]    out_y,
   output logic [CW-1:0] out_colour,
   output logic          scan_busy,
   output logic          frame_done,
   output logic [7:0]    oob_count
);

   localparam int unsigned DEPTH = WIDTH * HEIGHT;
   localparam int unsigned AW    = 15;
   localparam logic [7:0]  X_END = 8'(WIDTH);
   localparam logic [6:0]  Y_END = 7'(HEIGHT);
   localparam logic [7:0]  X_MAX = 8'(WIDTH - 1);
   localparam logic [6:0]  Y_MAX = 7'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   logic [CW-1:0] mem [DEPTH];

   state_t        state, state_nxt;
   logic [7:0]    rd_x, rd_x_nxt;
   logic [6:0]    rd_y, rd_y_nxt;
   logic          valid_nxt;
   logic          done_nxt;
   logic          issue_c;
   logic          in_range_c;
   logic [AW-1:0] wr_addr_c;
   logic [AW-1:0] rd_addr_c;

   assign in_range_c = (x < X_END) && (y < Y_END);
   assign wr_addr_c  = AW'(y) * AW'(WIDTH) + AW'(x);
   assign rd_addr_c  = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

   // Frame buffer write port; contents survive reset so a frame can be read back after one.
   always_ff @(posedge clk) begin
      if (plot && in_range_c) begin
         mem[wr_addr_c] <= colour;
      end
   end

   // Next-state and scan counter control
   always_comb begin
      state_nxt = state;
      rd_x_nxt  = rd_x;
      rd_y_nxt  = rd_y;
      valid_nxt = out_valid;
      done_nxt  = 1'b0;
      issue_c   = 1'b0;
      case (state)
         IDLE: begin
            if (scan_start) begin
               state_nxt = SCAN;
               rd_x_nxt  = 8'd0;
               rd_y_nxt  = 7'd0;
            end
         end
         SCAN: begin
            if (!out_valid || out_ready) begin
               issue_c   = 1'b1;
               valid_nxt = 1'b1;
               if (rd_x == X_MAX) begin
                  rd_x_nxt = 8'd0;
                  if (rd_y == Y_MAX) begin
                     state_nxt = DRAIN;
                  end else begin
                     rd_y_nxt = rd_y + 7'd1;
                  end
               end else begin
                  rd_x_nxt = rd_x + 8'd1;
               end
            end
         end
         DRAIN: begin
            // out_valid is always set here: the last pixel waits for acceptance
            if (out_ready) begin
               valid_nxt = 1'b0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and registered output stage (RAM read register doubles as output)
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         rd_x       <= 8'd0;
         rd_y       <= 7'd0;
         out_valid  <= 1'b0;
         out_x      <= 8'd0;
         out_y      <= 7'd0;
         out_colour <= '0;
         scan_busy  <= 1'b0;
         frame_done <= 1'b0;
         oob_count  <= 8'd0;
      end else begin
         state      <= state_nxt;
         rd_x       <= rd_x_nxt;
         rd_y       <= rd_y_nxt;
         out_valid  <= valid_nxt;
         scan_busy  <= (state_nxt != IDLE);
         frame_done <= done_nxt;
         if (issue_c) begin
            out_x      <= rd_x;
            out_y      <= rd_y;
            out_colour <= mem[rd_addr_c];
         end
         if (plot && !in_range_c && (oob_count != 8'hFF)) begin
            oob_count <= oob_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Scoreboard bench for fb_pixel_sink: plots directed pixels, queues the expected raster
// stream at each scan_start, and a monitor checks every accepted beat against the queue.
module tb_fb_pixel_sink;

   localparam int W = 160;
   localparam int H = 120;
   localparam int N = W * H;

   logic       clk;
   logic       resetn;
   logic [7:0] x;
   logic [6:0] y;
   logic [8:0] colour;
   logic       plot;
   logic       scan_start;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_x;
   logic [6:0] out_y;
   logic [8:0] out_colour;
   logic       scan_busy;
   logic       frame_done;
   logic [7:0] oob_count;

   fb_pixel_sink dut (
      .clk        (clk),
      .resetn     (resetn),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .scan_start (scan_start),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_colour (out_colour),
      .scan_busy  (scan_busy),
      .frame_done (frame_done),
      .oob_count  (oob_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [8:0] c;
      bit         known;
   } beat_t;

   beat_t      q[$];
   logic [8:0] model [N];
   bit         known [N];

   int n_checks = 0;
   int n_fail   = 0;
   int total_beats = 0;
   int done_pulses = 0;
   int base_beats  = 0;
   int base_done   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: samples 1 time unit after each falling edge, i.e. the values the next rising edge sees.
   bit         expect_done = 0;
   bit         stalled = 0;
   logic [7:0] held_x;
   logic [6:0] held_y;
   logic [8:0] held_c;

   always @(negedge clk) begin
      beat_t e;
      #1;
      if (!resetn) begin
         q.delete();
         expect_done = 0;
         stalled     = 0;
      end else begin
         if (expect_done) begin
            chk("frame_done_after_last", int'(frame_done), 1);
            chk("valid_after_last", int'(out_valid), 0);
            if (frame_done) done_pulses++;
            expect_done = 0;
         end else begin
            if (frame_done) chk("frame_done_unexpected", int'(frame_done), 0);
         end
         if (stalled) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_x", int'(out_x), int'(held_x));
            chk("stall_y", int'(out_y), int'(held_y));
            chk("stall_colour", int'(out_colour), int'(held_c));
         end
         if (out_valid && out_ready) begin
            stalled = 0;
            chk("sb_nonempty", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("beat_x", int'(out_x), int'(e.x));
               chk("beat_y", int'(out_y), int'(e.y));
               if (e.known) chk("beat_colour", int'(out_colour), int'(e.c));
               chk("busy_during_beat", int'(scan_busy), 1);
               if (e.x == 8'(W - 1) && e.y == 7'(H - 1)) expect_done = 1;
            end
            total_beats++;
         end else if (out_valid) begin
            stalled = 1;
            held_x  = out_x;
            held_y  = out_y;
            held_c  = out_colour;
         end else begin
            stalled = 0;
         end
      end
   end

   task automatic do_plot(input int px, input int py, input logic [8:0] pc);
      plot   = 1'b1;
      x      = 8'(px);
      y      = 7'(py);
      colour = pc;
      @(negedge clk);
      plot = 1'b0;
      if (px < W && py < H) begin
         model[py * W + px] = pc;
         known[py * W + px] = 1'b1;
      end
   endtask

   task automatic issue_scan();
      for (int i = 0; i < N; i++) begin
         q.push_back('{x: 8'(i % W), y: 7'(i / W), c: model[i], known: known[i]});
      end
      base_beats = total_beats;
      base_done  = done_pulses;
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int limit);
      int k = 0;
      while ((total_beats - base_beats) < n && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("wait_beats_in_time", int'((total_beats - base_beats) >= n), 1);
   endtask

   task automatic wait_done(input int limit);
      int k = 0;
      while (done_pulses == base_done && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("frame_done_in_time", int'(done_pulses > base_done), 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_scan_busy"}, int'(scan_busy), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_oob_count"}, int'(oob_count), 0);
      chk({tag, "_out_x"}, int'(out_x), 0);
      chk({tag, "_out_y"}, int'(out_y), 0);
      chk({tag, "_out_colour"}, int'(out_colour), 0);
   endtask

   initial begin
      int k;
      resetn     = 1'b0;
      plot       = 1'b0;
      x          = 8'd0;
      y          = 7'd0;
      colour     = 9'd0;
      scan_start = 1'b0;
      out_ready  = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      resetn = 1'b1;

      // Directed pixels, including both frame corners and the row-1 alias target of x=160
      do_plot(5, 3, 9'h1C7);
      do_plot(10, 0, 9'h055);
      do_plot(0, 1, 9'h0AA);
      do_plot(159, 119, 9'h1FF);
      do_plot(0, 0, 9'h123);
      do_plot(159, 0, 9'h0F0);
      do_plot(160, 0, 9'h1EE);
      do_plot(0, 120, 9'h1EE);
      chk("oob_two", int'(oob_count), 2);
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) do_plot(200, 5, 9'h1EE);
         else            do_plot(3, 127, 9'h1EE);
      end
      chk("oob_saturated", int'(oob_count), 255);
      chk("idle_not_busy", int'(scan_busy), 0);

      // Scan 1: ready high, same-cycle write of (10,0) while it is read, restart pulse at beat 100
      out_ready = 1'b1;
      issue_scan();
      chk("busy_after_start", int'(scan_busy), 1);
      @(negedge clk);
      chk("first_valid", int'(out_valid), 1);
      chk("first_x", int'(out_x), 0);
      repeat (9) @(negedge clk);
      do_plot(10, 0, 9'h1B2);
      wait_beats(100, 1000);
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      wait_done(25000);
      repeat (5) @(negedge clk);
      chk("scan1_beats", total_beats - base_beats, N);
      chk("scan1_done_pulses", done_pulses - base_done, 1);
      chk("scan1_idle", int'(scan_busy), 0);
      chk("scan1_queue_empty", int'(q.size()), 0);

      // Scan 2: ready pattern 1,0,0 for the first 600 beats, then held high
      issue_scan();
      k = 0;
      while (done_pulses == base_done && k < 60000) begin
         if ((total_beats - base_beats) < 600) out_ready = (k % 3 == 0);
         else                                  out_ready = 1'b1;
         @(negedge clk);
         k++;
      end
      out_ready = 1'b1;
      chk("scan2_done_in_time", int'(done_pulses > base_done), 1);
      repeat (3) @(negedge clk);
      chk("scan2_beats", total_beats - base_beats, N);
      chk("scan2_done_pulses", done_pulses - base_done, 1);

      // Scan 3: reset at beat 50 aborts the scan
      issue_scan();
      wait_beats(50, 1000);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk_reset_outputs("midscan_reset");
      repeat (20) @(negedge clk);
      chk("no_done_after_reset", done_pulses - base_done, 0);
      chk("idle_after_reset", int'(scan_busy), 0);
      chk("no_beats_after_reset", int'(out_valid), 0);

      // Scan 4: frame survives reset; check the first 600 beats (covers beat 485 = (5,3))
      issue_scan();
      wait_beats(600, 2000);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("final_reset_valid", int'(out_valid), 0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
